// File: rtl/peripheral_pkg.sv
// rtl/peripheral_pkg.sv - register map and bit positions for the channel bank
package peripheral_pkg;

  // Word offsets inside one channel's 4-word window
  localparam int REGS_PER_CH  = 4;
  localparam int REG_COUNTER  = 0;
  localparam int REG_CONFIG   = 1;
  localparam int REG_STATUS   = 2;
  localparam int REG_COMPARE  = 3;

  // Config register bit positions
  localparam int CFG_EN       = 0;
  localparam int CFG_DIR      = 1;
  localparam int CFG_IE       = 2;

  // Status register bit positions
  localparam int ST_LT        = 0;
  localparam int ST_WRAP      = 1;
  localparam int ST_MATCH     = 2;

  // Packed so that field bits line up with CFG_* positions
  typedef struct packed {
    logic int_en;
    logic dir_up;
    logic enable;
  } chan_cfg_t;

  // The pending vector sits just past the last channel window
  function automatic int pending_addr(input int channels);
    return channels * REGS_PER_CH;
  endfunction

endpackage

// File: rtl/peripheral_counter_channel.sv
// rtl/peripheral_counter_channel.sv - one counter channel with compare, config and sticky flags
module peripheral_counter_channel
  import peripheral_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_counter_i,
  input  logic                   wr_config_i,
  input  logic                   wr_status_i,
  input  logic                   wr_compare_i,
  input  logic [COUNT_WIDTH-1:0] wdata_i,
  output logic [COUNT_WIDTH-1:0] counter_o,
  output logic [COUNT_WIDTH-1:0] compare_o,
  output chan_cfg_t              config_o,
  output logic                   wrap_o,
  output logic                   match_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic [COUNT_WIDTH-1:0] compare_q, compare_d;
  logic [COUNT_WIDTH-1:0] stepped;
  chan_cfg_t              cfg_q, cfg_d;
  logic                   wrap_q, wrap_d;
  logic                   match_q, match_d;
  logic                   wrap_hit;

  // Next state: software write beats the step, and the step uses the config/compare already held
  always_comb begin
    stepped   = cfg_q.dir_up ? counter_q + CNT_ONE : counter_q - CNT_ONE;
    wrap_hit  = cfg_q.enable && !wr_counter_i &&
                (cfg_q.dir_up ? (counter_q == CNT_MAX) : (counter_q == '0));
    counter_d = counter_q;
    if (wr_counter_i) begin
      counter_d = wdata_i;
    end else if (cfg_q.enable) begin
      counter_d = stepped;
    end
    cfg_d     = wr_config_i  ? chan_cfg_t'(wdata_i[2:0]) : cfg_q;
    compare_d = wr_compare_i ? wdata_i : compare_q;
    // A hardware set in the same cycle as a W1C leaves the flag set
    wrap_d    = wrap_hit | (wrap_q & ~(wr_status_i & wdata_i[ST_WRAP]));
    match_d   = ((wr_counter_i | cfg_q.enable) & (counter_d == compare_q)) |
                (match_q & ~(wr_status_i & wdata_i[ST_MATCH]));
  end

  // Channel state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      compare_q <= '0;
      cfg_q     <= '0;
      wrap_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      counter_q <= counter_d;
      compare_q <= compare_d;
      cfg_q     <= cfg_d;
      wrap_q    <= wrap_d;
      match_q   <= match_d;
    end
  end

  assign counter_o = counter_q;
  assign compare_o = compare_q;
  assign config_o  = cfg_q;
  assign wrap_o    = wrap_q;
  assign match_o   = match_q;

endmodule

// File: rtl/peripheral_channel_bank.sv
// rtl/peripheral_channel_bank.sv - bank of counter channels behind a word-addressed register port
module peripheral_channel_bank
  import peripheral_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic                            write_en,
  input  logic                            read_en,
  input  logic [31:0]                     data_in,
  output logic [31:0]                     data_out,
  output logic                            read_valid,
  output logic                            irq,
  output logic [CHANNELS*COUNT_WIDTH-1:0] count_out
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_chan_check
    $error("CHANNELS must be 1..16");
  end
  if (COUNT_WIDTH < 8 || COUNT_WIDTH > 32) begin : g_width_check
    $error("COUNT_WIDTH must be 8..32");
  end
  if (CHANNELS * REGS_PER_CH + 1 > 2 ** ADDR_WIDTH) begin : g_addr_check
    $error("ADDR_WIDTH too small for CHANNELS");
  end

  logic [COUNT_WIDTH-1:0] ch_counter [CHANNELS];
  logic [COUNT_WIDTH-1:0] ch_compare [CHANNELS];
  chan_cfg_t              ch_cfg     [CHANNELS];
  logic [CHANNELS-1:0]    ch_wrap, ch_match, pending;
  logic [31:0]            rdata, data_d, data_q;
  logic                   rd_fire, read_valid_q, irq_q;

  assign rd_fire = read_en & ~write_en;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int BASE = c * REGS_PER_CH;

    peripheral_counter_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_counter_i(write_en && (addr == ADDR_WIDTH'(BASE + REG_COUNTER))),
      .wr_config_i (write_en && (addr == ADDR_WIDTH'(BASE + REG_CONFIG))),
      .wr_status_i (write_en && (addr == ADDR_WIDTH'(BASE + REG_STATUS))),
      .wr_compare_i(write_en && (addr == ADDR_WIDTH'(BASE + REG_COMPARE))),
      .wdata_i     (data_in[COUNT_WIDTH-1:0]),
      .counter_o   (ch_counter[c]),
      .compare_o   (ch_compare[c]),
      .config_o    (ch_cfg[c]),
      .wrap_o      (ch_wrap[c]),
      .match_o     (ch_match[c])
    );

    assign count_out[c*COUNT_WIDTH +: COUNT_WIDTH] = ch_counter[c];
    assign pending[c] = ch_cfg[c].int_en & (ch_wrap[c] | ch_match[c]);
  end

  // Read mux over the current (pre-update) register state; unmapped addresses give 0
  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr == ADDR_WIDTH'(c * REGS_PER_CH + REG_COUNTER)) rdata = 32'(ch_counter[c]);
      if (addr == ADDR_WIDTH'(c * REGS_PER_CH + REG_CONFIG))  rdata = {29'b0, ch_cfg[c]};
      if (addr == ADDR_WIDTH'(c * REGS_PER_CH + REG_STATUS))
        rdata = {29'b0, ch_match[c], ch_wrap[c], ch_counter[c] < ch_compare[c]};
      if (addr == ADDR_WIDTH'(c * REGS_PER_CH + REG_COMPARE)) rdata = 32'(ch_compare[c]);
    end
    if (addr == ADDR_WIDTH'(pending_addr(CHANNELS))) rdata = 32'(pending);
    data_d = rd_fire ? rdata : data_q;
  end

  // Read data holds between reads; irq is the registered OR of pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      read_valid_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      data_q       <= data_d;
      read_valid_q <= rd_fire;
      irq_q        <= |pending;
    end
  end

  assign data_out   = data_q;
  assign read_valid = read_valid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_peripheral_channel_bank.sv
// tb/tb_peripheral_channel_bank.sv - directed self-checking bench for peripheral_channel_bank
module tb_peripheral_channel_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   addr;
  logic         write_en, read_en;
  logic [31:0]  data_in, data_out;
  logic         read_valid, irq;
  logic [127:0] count_out;

  logic [2:0]   s_addr;
  logic         s_write_en, s_read_en;
  logic [31:0]  s_data_in, s_data_out;
  logic         s_read_valid, s_irq;
  logic [7:0]   s_count_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_channel_bank #(.CHANNELS(4), .COUNT_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .read_valid(read_valid), .irq(irq),
    .count_out(count_out)
  );

  peripheral_channel_bank #(.CHANNELS(1), .COUNT_WIDTH(8), .ADDR_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .addr(s_addr), .write_en(s_write_en), .read_en(s_read_en),
    .data_in(s_data_in), .data_out(s_data_out), .read_valid(s_read_valid), .irq(s_irq),
    .count_out(s_count_out)
  );

  // All access tasks start and end on a falling edge
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; data_in = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic v);
    addr = a; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    d = data_out; v = read_valid;
  endtask

  task automatic s_wr(input logic [2:0] a, input logic [31:0] d);
    s_addr = a; s_data_in = d; s_write_en = 1'b1;
    @(negedge clk);
    s_write_en = 1'b0;
  endtask

  task automatic s_rd(input logic [2:0] a, output logic [31:0] d, output logic v);
    s_addr = a; s_read_en = 1'b1;
    @(negedge clk);
    s_read_en = 1'b0;
    d = s_data_out; v = s_read_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    reset = 1'b1;
    addr = '0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    s_addr = '0; s_write_en = 1'b0; s_read_en = 1'b0; s_data_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if (data_out !== 32'h0 || read_valid !== 1'b0 || irq !== 1'b0 || count_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h valid=%b irq=%b count=%h want all 0", data_out, read_valid, irq, count_out);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a <= 16; a++) begin
      rd(8'(a), d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin
        bad++;
        $display("FAIL reset_read addr=%0d: data=%h valid=%b want data=0 valid=1", a, d, v);
      end
    end
    @(negedge clk);
    total++;
    if (read_valid !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: valid=%b irq=%b want 0 0", read_valid, irq);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic v;
    wr(8'd16, 32'hF);
    wr(8'd20, 32'hDEAD_BEEF);
    rd(8'd16, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL pending_write_ignored: data=%h valid=%b want 0 1", d, v); end
    rd(8'd20, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmapped_20: data=%h want 0", d); end
    rd(8'd255, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmapped_255: data=%h want 0", d); end
    addr = 8'd20; data_in = 32'h1; write_en = 1'b1; read_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
    total++;
    if (read_valid !== 1'b0) begin bad++; $display("FAIL read_with_write: valid=%b want 0", read_valid); end
  endtask

  task automatic test_wrap_irq();
    logic [31:0] d;
    logic v;
    wr(8'd7, 32'h8000_0000);
    wr(8'd4, 32'hFFFF_FFFE);
    wr(8'd5, 32'h7);
    @(negedge clk);
    total++;
    if (count_out[63:32] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_step1: count=%h want ffffffff", count_out[63:32]); end
    @(negedge clk);
    total++;
    if (count_out[63:32] !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL wrap_to_zero: count=%h irq=%b want 0 0", count_out[63:32], irq);
    end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq: irq=%b want 1", irq); end
    rd(8'd6, d, v);
    total++;
    if (d !== 32'h3 || v !== 1'b1) begin bad++; $display("FAIL wrap_status: data=%h valid=%b want 3 1", d, v); end
    rd(8'd16, d, v);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL wrap_pending: data=%h want 2", d); end
    wr(8'd6, 32'h2);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq_lag: irq=%b want 1", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL wrap_w1c_irq: irq=%b want 0", irq); end
    wr(8'd5, 32'h0);
  endtask

  task automatic test_match();
    logic [31:0] d;
    logic v;
    wr(8'd3, 32'd10);
    wr(8'd1, 32'h7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      total++;
      if (count_out[31:0] !== 32'(k)) begin bad++; $display("FAIL match_count k=%0d: count=%h", k, count_out[31:0]); end
    end
    rd(8'd2, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL match_status_below: data=%h want 1", d); end
    total++;
    if (count_out[31:0] !== 32'd10) begin bad++; $display("FAIL match_count10: count=%h want a", count_out[31:0]); end
    rd(8'd2, d, v);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL match_status_hit: data=%h want 4", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL match_irq: irq=%b want 1", irq); end
    @(negedge clk);
    total++;
    if (data_out !== 32'h4 || read_valid !== 1'b0) begin
      bad++; $display("FAIL data_hold: data=%h valid=%b want 4 0", data_out, read_valid);
    end
    wr(8'd1, 32'h0);
    wr(8'd2, 32'h4);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL match_clear_irq: irq=%b want 0", irq); end
  endtask

  task automatic test_down_wrap();
    logic [31:0] d;
    logic v;
    wr(8'd9, 32'h5);
    wr(8'd10, 32'h2);
    total++;
    if (count_out[95:64] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL down_count: count=%h want ffffffff", count_out[95:64]); end
    rd(8'd10, d, v);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL down_set_beats_clear: status=%h want 2", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL down_irq: irq=%b want 1", irq); end
    wr(8'd9, 32'h0);
    wr(8'd10, 32'h2);
    rd(8'd10, d, v);
    total++;
    if (d !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL down_cleared: status=%h irq=%b want 0 0", d, irq); end
  endtask

  task automatic test_write_priority();
    logic [31:0] d;
    logic v;
    wr(8'd12, 32'hFFFF_FFFF);
    wr(8'd13, 32'h3);
    wr(8'd12, 32'h5);
    total++;
    if (count_out[127:96] !== 32'h5) begin bad++; $display("FAIL prio_count: count=%h want 5", count_out[127:96]); end
    rd(8'd12, d, v);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL prio_read: data=%h want 5", d); end
    rd(8'd14, d, v);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL prio_no_wrap: status=%h want 0", d); end
    wr(8'd13, 32'h0);
  endtask

  task automatic test_small();
    logic [31:0] d;
    logic v;
    s_wr(3'd0, 32'h1FE);
    s_rd(3'd0, d, v);
    total++;
    if (d !== 32'hFE || v !== 1'b1) begin bad++; $display("FAIL small_trunc: data=%h valid=%b want fe 1", d, v); end
    s_wr(3'd3, 32'h80);
    s_wr(3'd1, 32'h7);
    @(negedge clk);
    total++;
    if (s_count_out !== 8'hFF) begin bad++; $display("FAIL small_ff: count=%h want ff", s_count_out); end
    @(negedge clk);
    total++;
    if (s_count_out !== 8'h00) begin bad++; $display("FAIL small_wrap: count=%h want 00", s_count_out); end
    s_rd(3'd4, d, v);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL small_pending: data=%h want 1", d); end
    s_rd(3'd5, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL small_unmapped: data=%h valid=%b want 0 1", d, v); end
    s_rd(3'd2, d, v);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL small_status: data=%h want 3", d); end
    s_rd(3'd1, d, v);
    total++;
    if (d !== 32'h7 || s_irq !== 1'b1) begin bad++; $display("FAIL small_cfg_irq: cfg=%h irq=%b want 7 1", d, s_irq); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic v;
    wr(8'd0, 32'h55);
    addr = 8'd0; read_en = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    total++;
    if (read_valid !== 1'b0 || data_out !== 32'h0 || count_out !== 128'h0 || s_count_out !== 8'h0) begin
      bad++; $display("FAIL mid_read_reset: valid=%b data=%h count=%h want 0", read_valid, data_out, count_out);
    end
    reset = 1'b0;
    @(negedge clk);
    rd(8'd0, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1 || irq !== 1'b0) begin
      bad++; $display("FAIL after_reset_read: data=%h valid=%b irq=%b want 0 1 0", d, v, irq);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unmapped();
    test_wrap_irq();
    test_match();
    test_down_wrap();
    test_write_priority();
    test_small();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
